// File: rtl/serial_chain_pkg.sv
// rtl/serial_chain_pkg.sv - shared state encoding and elaboration helpers for serial_chain_driver
package serial_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

  // Ceiling log2, used to size counters at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ser_tick_gen.sv
// rtl/ser_tick_gen.sv - phase tick every HALF clk cycles with synchronous clear
module ser_tick_gen
  import serial_chain_pkg::*;
#(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DW = clog2(HALF + 1);
  localparam logic [DW-1:0] LAST = DW'(HALF - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // Count 0..HALF-1 and wrap; a clear restarts the half-period from zero.
  always_comb begin
    div_d = div_q + DW'(1);
    if (clr_i || (div_q == LAST)) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = (div_q == LAST);

endmodule

// File: rtl/serial_chain_driver.sv
// rtl/serial_chain_driver.sv - parallel-to-serial driver for shift-register display chains
module serial_chain_driver
  import serial_chain_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int NCH       = 1,
  parameter int HALF      = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] data,
  input  logic                 refresh,
  output logic                 sclk,
  output logic [NCH-1:0]       sdat,
  output logic                 slat,
  output logic                 sclr_n,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 sclk_q, sclk_d;
  logic                 slat_q, slat_d;
  logic                 done_q, done_d;
  logic                 pending_q, pending_d;
  logic                 busy_q;
  logic                 sclr_q;
  logic [NCH*WIDTH-1:0] sent_q;
  logic                 load;
  logic                 adv;
  logic                 tick;
  logic                 trig;

  ser_tick_gen #(
    .HALF (HALF)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (load),
    .tick_o (tick)
  );

  // During LOAD the captured value is the current data, so only refresh re-arms.
  assign trig = refresh | ((state_q != LOAD) && (data != sent_q));

  // Next-state and registered-output decode; sclk_q doubles as the bit phase.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    slat_d    = slat_q;
    done_d    = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    pending_d = pending_q | trig;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end
      end
      LOAD: begin
        load    = 1'b1;
        bit_d   = '0;
        sclk_d  = 1'b0;
        slat_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              state_d = LATCH;
              slat_d  = 1'b1;
            end else begin
              bit_d = bit_q + BW'(1);
              adv   = 1'b1;
            end
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_d = IDLE;
          slat_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; pending starts set so a frame follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      slat_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sclr_q    <= 1'b0;
      pending_q <= 1'b1;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      slat_q    <= slat_d;
      done_q    <= done_d;
      busy_q    <= (state_d != IDLE);
      sclr_q    <= 1'b1;
      pending_q <= pending_d;
      if (load) begin
        sent_q <= data;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chain
    if (MSB_FIRST) begin : g_msb
      logic [WIDTH-1:0] sr_q;
      // Shift toward the MSB; the top bit is the line being driven.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '0;
        end else if (load) begin
          sr_q <= data[c*WIDTH +: WIDTH];
        end else if (adv) begin
          sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
      end
      assign sdat[c] = sr_q[WIDTH-1];
    end else begin : g_lsb
      logic [WIDTH-1:0] sr_q;
      // Shift toward the LSB; bit 0 is the line being driven.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '0;
        end else if (load) begin
          sr_q <= data[c*WIDTH +: WIDTH];
        end else if (adv) begin
          sr_q <= {1'b0, sr_q[WIDTH-1:1]};
        end
      end
      assign sdat[c] = sr_q[0];
    end
  end

  assign sclk   = sclk_q;
  assign slat   = slat_q;
  assign sclr_n = sclr_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_chain_driver.sv
// tb/tb_serial_chain_driver.sv - directed self-checking bench for serial_chain_driver
module tb_serial_chain_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic        refresh;

  logic        sclk_m, slat_m, sclr_n_m, busy_m, done_m;
  logic [1:0]  sdat_m;
  logic        sclk_l, slat_l, sclr_n_l, busy_l, done_l;
  logic [1:0]  sdat_l;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_chain_driver #(.WIDTH(8), .NCH(2), .HALF(2), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .data(data), .refresh(refresh),
    .sclk(sclk_m), .sdat(sdat_m), .slat(slat_m), .sclr_n(sclr_n_m),
    .busy(busy_m), .done(done_m)
  );

  serial_chain_driver #(.WIDTH(8), .NCH(2), .HALF(2), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .data(data), .refresh(refresh),
    .sclk(sclk_l), .sdat(sdat_l), .slat(slat_l), .sclr_n(sclr_n_l),
    .busy(busy_l), .done(done_l)
  );

  // Collect one frame: bits as received on sclk rises (first bit ends up in bit 7),
  // cycles from LOAD to done, slat cycles and sclk rises.
  task automatic capture(input int change_at, input logic [15:0] nd,
                         output logic [31:0] bits, output int len,
                         output int slen, output int rises);
    logic [7:0] m0, m1, l0, l1;
    logic       pm, pl;
    int         guard;
    m0 = '0; m1 = '0; l0 = '0; l1 = '0;
    bits = '0; len = 0; slen = 0; rises = 0; guard = 0;
    while (!busy_m && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (busy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start: busy=%b required 1 within 100 cycles", busy_m);
      return;
    end
    pm = sclk_m;
    pl = sclk_l;
    while (!done_m && len < 200) begin
      @(negedge clk);
      len++;
      if (len == change_at) data = nd;
      if (sclk_m && !pm) begin
        m0 = {m0[6:0], sdat_m[0]};
        m1 = {m1[6:0], sdat_m[1]};
        rises++;
      end
      if (sclk_l && !pl) begin
        l0 = {l0[6:0], sdat_l[0]};
        l1 = {l1[6:0], sdat_l[1]};
      end
      if (slat_m) slen++;
      pm = sclk_m;
      pl = sclk_l;
    end
    bits = {m0, m1, l0, l1};
  endtask

  task automatic test_reset();
    logic [31:0] bits;
    int len, slen, rises, act;
    rst_n = 1'b0; data = 16'h0000; refresh = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({sclk_m, sdat_m, slat_m, sclr_n_m, busy_m, done_m,
         sclk_l, sdat_l, slat_l, sclr_n_l, busy_l, done_l} !== 14'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got m=%b%b%b%b%b%b l=%b%b%b%b%b%b required all 0",
               sclk_m, sdat_m, slat_m, sclr_n_m, busy_m, done_m,
               sclk_l, sdat_l, slat_l, sclr_n_l, busy_l, done_l);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({sclr_n_m, sclr_n_l, busy_m} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_first_edge: sclr_n=%b%b busy=%b required 11 1", sclr_n_m, sclr_n_l, busy_m);
    end
    capture(-1, 16'h0, bits, len, slen, rises);
    n_chk++;
    if (bits !== 32'h0) begin n_fail++; $display("FAIL reset_frame_bits: got %h required 00000000", bits); end
    n_chk++;
    if (len !== 35) begin n_fail++; $display("FAIL reset_frame_len: got %0d required 35", len); end
    n_chk++;
    if (slen !== 2 || rises !== 8) begin
      n_fail++; $display("FAIL reset_frame_shape: slat=%0d rises=%0d required 2 8", slen, rises);
    end
    @(negedge clk);
    n_chk++;
    if ({done_m, busy_m} !== 2'b00) begin
      n_fail++; $display("FAIL done_width: done=%b busy=%b required 0 0", done_m, busy_m);
    end
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_m || busy_l) act++;
    end
    n_chk++;
    if (act !== 0) begin n_fail++; $display("FAIL reset_single_frame: busy cycles %0d required 0", act); end
  endtask

  task automatic test_msb_lsb();
    logic [31:0] bits;
    int len, slen, rises;
    data = 16'hA53C;
    @(negedge clk);
    n_chk++;
    if (busy_m !== 1'b0) begin n_fail++; $display("FAIL trig_pending_cycle: busy=%b required 0", busy_m); end
    @(negedge clk);
    n_chk++;
    if (busy_m !== 1'b1) begin n_fail++; $display("FAIL trig_load_cycle: busy=%b required 1", busy_m); end
    capture(-1, 16'h0, bits, len, slen, rises);
    n_chk++;
    if (bits !== 32'h3CA53CA5) begin n_fail++; $display("FAIL a53c_bits: got %h required 3ca53ca5", bits); end
    n_chk++;
    if (len !== 35 || slen !== 2) begin
      n_fail++; $display("FAIL a53c_timing: len=%0d slat=%0d required 35 2", len, slen);
    end
  endtask

  task automatic test_mid_change();
    logic [31:0] bits;
    int len, slen, rises;
    data = 16'h5AC3;
    capture(10, 16'h0001, bits, len, slen, rises);
    n_chk++;
    if (bits !== 32'hC35AC35A) begin n_fail++; $display("FAIL midchg_first_bits: got %h required c35ac35a", bits); end
    n_chk++;
    if (len !== 35) begin n_fail++; $display("FAIL midchg_first_len: got %0d required 35", len); end
    @(negedge clk);
    n_chk++;
    if ({busy_m, done_m} !== 2'b10) begin
      n_fail++; $display("FAIL back_to_back_load: busy=%b done=%b required 1 0", busy_m, done_m);
    end
    capture(-1, 16'h0, bits, len, slen, rises);
    n_chk++;
    if (bits !== 32'h01008000) begin n_fail++; $display("FAIL midchg_second_bits: got %h required 01008000", bits); end
    n_chk++;
    if (len !== 35) begin n_fail++; $display("FAIL midchg_second_len: got %0d required 35", len); end
  endtask

  task automatic test_idle_refresh();
    logic [31:0] bits;
    int len, slen, rises, act;
    act = 0;
    repeat (200) begin
      @(negedge clk);
      if (sclk_m || sclk_l || busy_m) act++;
    end
    n_chk++;
    if (act !== 0) begin n_fail++; $display("FAIL idle_quiet: active cycles %0d required 0", act); end
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    capture(-1, 16'h0, bits, len, slen, rises);
    n_chk++;
    if (bits !== 32'h01008000 || rises !== 8) begin
      n_fail++; $display("FAIL refresh_frame: bits=%h rises=%0d required 01008000 8", bits, rises);
    end
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy_m || busy_l) act++;
    end
    n_chk++;
    if (act !== 0) begin n_fail++; $display("FAIL refresh_single: busy cycles %0d required 0", act); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits;
    int len, slen, rises, guard;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    guard = 0;
    while (!busy_m && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({sclk_m, sdat_m, slat_m, sclr_n_m, busy_m, done_m,
         sclk_l, sdat_l, slat_l, sclr_n_l, busy_l, done_l} !== 14'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got m=%b%b%b%b%b%b l=%b%b%b%b%b%b required all 0",
               sclk_m, sdat_m, slat_m, sclr_n_m, busy_m, done_m,
               sclk_l, sdat_l, slat_l, sclr_n_l, busy_l, done_l);
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture(-1, 16'h0, bits, len, slen, rises);
    n_chk++;
    if (bits !== 32'h01008000) begin n_fail++; $display("FAIL midreset_bits: got %h required 01008000", bits); end
    n_chk++;
    if (len !== 35 || slen !== 2) begin
      n_fail++; $display("FAIL midreset_timing: len=%0d slat=%0d required 35 2", len, slen);
    end
  endtask

  initial begin
    test_reset();
    test_msb_lsb();
    test_mid_change();
    test_idle_refresh();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
